// File: rtl/spi_master_slave_pair.sv
// spi_master_slave_pair: mode-0 MSB-first SPI master (divided sclk) and oversampling SPI slave
// sharing one system clock; each engine moves one 8-bit frame per ss assertion.
module spi_master_slave_pair #(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             m_start,
  input  logic             m_write_enable,
  input  logic [2:0]       m_clock_div,
  input  logic [WIDTH-1:0] m_data_tx,
  input  logic             m_miso,
  output logic             m_sclk,
  output logic             m_ss,
  output logic             m_mosi,
  output logic [WIDTH-1:0] m_data_rx,
  output logic             m_done,
  input  logic             s_sclk,
  input  logic             s_ss,
  input  logic             s_mosi,
  input  logic             s_write_enable,
  input  logic [WIDTH-1:0] s_data_tx,
  output logic             s_miso,
  output logic [WIDTH-1:0] s_data_rx,
  output logic             s_done
);
  typedef enum logic [2:0] {M_IDLE, M_SETUP, M_HIGH, M_LOW, M_FINISH} m_state_t;
  m_state_t m_state, m_next;
  logic start_d, m_we, h_last, start_edge, last_bit;
  logic [2:0] m_div, m_bits;
  logic [5:0] h_cnt;
  logic [6:0] half;
  logic [WIDTH-1:0] m_sr;
  assign start_edge = m_start & ~start_d;
  assign half = (m_div == 3'd0) ? 7'd1 : 7'd1 << (m_div - 3'd1);
  assign h_last = {1'b0, h_cnt} == half - 7'd1;
  assign last_bit = m_bits == 3'(WIDTH - 1);
  always_comb begin
    m_next = m_state;
    case (m_state)
      M_IDLE:         m_next = start_edge ? M_SETUP : M_IDLE;
      M_SETUP, M_LOW: m_next = h_last ? M_HIGH : m_state;
      M_HIGH:         m_next = !h_last ? M_HIGH : last_bit ? M_FINISH : M_LOW;
      default:        m_next = M_IDLE;
    endcase
  end
  // one shift register serves both directions: tx bits leave the top while miso enters the bottom
  always_ff @(posedge clock) begin
    if (reset) begin
      m_state   <= M_IDLE;
      start_d   <= 1'b0;
      m_we      <= 1'b0;
      m_div     <= 3'd0;
      m_bits    <= 3'd0;
      h_cnt     <= 6'd0;
      m_sr      <= '0;
      m_sclk    <= 1'b0;
      m_ss      <= 1'b1;
      m_mosi    <= 1'b0;
      m_data_rx <= '0;
      m_done    <= 1'b0;
    end else begin
      m_state <= m_next;
      start_d <= m_start;
      m_done  <= 1'b0;
      h_cnt   <= (m_next == m_state && m_state != M_IDLE) ? h_cnt + 6'd1 : 6'd0;
      if (m_state == M_IDLE && start_edge) begin
        m_sr   <= m_data_tx;
        m_we   <= m_write_enable;
        m_div  <= m_clock_div;
        m_bits <= 3'd0;
        m_ss   <= 1'b0;
        m_mosi <= ~m_write_enable & m_data_tx[WIDTH-1];
      end
      if ((m_state == M_SETUP || m_state == M_LOW) && h_last) begin
        m_sclk <= 1'b1;
        m_sr   <= {m_sr[WIDTH-2:0], m_miso};
      end
      if (m_state == M_HIGH && h_last) begin
        m_sclk <= 1'b0;
        m_bits <= m_bits + 3'd1;
        m_mosi <= last_bit ? 1'b0 : ~m_we & m_sr[WIDTH-1];
      end
      if (m_state == M_FINISH) begin
        m_ss   <= 1'b1;
        m_mosi <= 1'b0;
        m_done <= 1'b1;
        if (m_we) m_data_rx <= m_sr;
      end
    end
  end
  logic [SYNC_STAGES-1:0] sclk_q, ss_q, mosi_q;
  logic sclk_s, ss_s, mosi_s, sclk_d, ss_d, s_we;
  logic [3:0] s_cnt;
  logic [WIDTH-1:0] s_rx_sr, s_tx_sr, rx_next;
  assign sclk_s  = sclk_q[SYNC_STAGES-1];
  assign ss_s    = ss_q[SYNC_STAGES-1];
  assign mosi_s  = mosi_q[SYNC_STAGES-1];
  assign rx_next = {s_rx_sr[WIDTH-2:0], mosi_s};
  // mosi shares the sclk synchronizer depth so the sampled bit lines up with the detected rise
  always_ff @(posedge clock) begin
    if (reset) begin
      sclk_q    <= '0;
      ss_q      <= '1;
      mosi_q    <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
      s_we      <= 1'b0;
      s_cnt     <= 4'd0;
      s_rx_sr   <= '0;
      s_tx_sr   <= '0;
      s_miso    <= 1'b0;
      s_data_rx <= '0;
      s_done    <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], s_sclk};
      ss_q   <= {ss_q[SYNC_STAGES-2:0], s_ss};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], s_mosi};
      sclk_d <= sclk_s;
      ss_d   <= ss_s;
      s_done <= 1'b0;
      if (ss_s) s_miso <= 1'b0;
      else if (ss_d) begin
        s_cnt   <= 4'd0;
        s_we    <= s_write_enable;
        s_tx_sr <= s_data_tx;
        s_miso  <= ~s_write_enable & s_data_tx[WIDTH-1];
      end else if (sclk_s && !sclk_d && s_cnt != 4'(WIDTH)) begin
        s_rx_sr <= rx_next;
        s_cnt   <= s_cnt + 4'd1;
        if (s_cnt == 4'(WIDTH - 1)) begin
          s_done <= 1'b1;
          if (s_we) s_data_rx <= rx_next;
        end
      end else if (!sclk_s && sclk_d && s_cnt != 4'(WIDTH)) begin
        s_tx_sr <= s_tx_sr << 1;
        s_miso  <= ~s_we & s_tx_sr[WIDTH-2];
      end
    end
  end
endmodule

// File: tb/tb_spi_master_slave_pair.sv
// tb_spi_master_slave_pair: loopback frames (table + random) against a byte-level model, plus abort/reset sequences
module tb_spi_master_slave_pair;
  logic clock = 1'b0, reset;
  logic m_start, m_write_enable, m_miso, m_sclk, m_ss, m_mosi, m_done;
  logic [2:0] m_clock_div;
  logic [7:0] m_data_tx, m_data_rx, s_data_tx, s_data_rx;
  logic s_sclk, s_ss, s_mosi, s_write_enable, s_miso, s_done;
  logic ext, x_sclk, x_ss, x_mosi;
  int checks = 0, failures = 0, md_total = 0, sd_total = 0;
  logic [7:0] exp_m_rx, exp_s_rx;

  assign s_sclk = ext ? x_sclk : m_sclk;
  assign s_ss   = ext ? x_ss : m_ss;
  assign s_mosi = ext ? x_mosi : m_mosi;
  assign m_miso = s_miso;

  spi_master_slave_pair dut (
    .clock(clock), .reset(reset), .m_start(m_start), .m_write_enable(m_write_enable),
    .m_clock_div(m_clock_div), .m_data_tx(m_data_tx), .m_miso(m_miso), .m_sclk(m_sclk),
    .m_ss(m_ss), .m_mosi(m_mosi), .m_data_rx(m_data_rx), .m_done(m_done),
    .s_sclk(s_sclk), .s_ss(s_ss), .s_mosi(s_mosi), .s_write_enable(s_write_enable),
    .s_data_tx(s_data_tx), .s_miso(s_miso), .s_data_rx(s_data_rx), .s_done(s_done)
  );

  always #5 clock = ~clock;
  always @(negedge clock) begin
    if (m_done) md_total++;
    if (s_done) sd_total++;
  end

  typedef struct {
    logic mwe, swe;
    logic [2:0] div;
    logic [7:0] mtx, stx, em, es;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic run_frame(input logic mwe, input logic swe, input logic [2:0] div,
                           input logic [7:0] mtx, input logic [7:0] stx, input bit hold);
    int h, n, rises, first_rise, last_rise, md, sd, mosi_hi;
    logic prev_sclk;
    bit seen;
    h = (div == 0) ? 1 : (1 << (div - 1));
    @(negedge clock);
    m_write_enable = mwe; s_write_enable = swe; m_clock_div = div;
    m_data_tx = mtx; s_data_tx = stx; m_start = 1'b0;
    @(negedge clock);
    m_start = 1'b1;
    n = 0; rises = 0; first_rise = 0; last_rise = 0; md = 0; sd = 0; mosi_hi = 0;
    prev_sclk = 1'b0; seen = 0;
    while (!seen && n < 2000) begin
      @(negedge clock);
      n++;
      if (m_sclk && !prev_sclk) begin
        rises++;
        if (rises == 1) first_rise = n;
        last_rise = n;
      end
      prev_sclk = m_sclk;
      if (mwe && m_mosi) mosi_hi++;
      if (s_done) sd++;
      if (m_done) begin md++; seen = 1; end
    end
    chk("frame_len", n, 2 + 16 * h);
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (m_done) md++;
      if (s_done) sd++;
      if (m_sclk && !prev_sclk) rises++;
      prev_sclk = m_sclk;
    end
    if (!hold) m_start = 1'b0;
    if (mwe) exp_m_rx = swe ? 8'h00 : stx;
    if (swe) exp_s_rx = mwe ? 8'h00 : mtx;
    chk("sclk_rises", rises, 8);
    chk("sclk_span", last_rise - first_rise, 14 * h);
    chk("m_done_pulses", md, 1);
    chk("s_done_pulses", sd, 1);
    chk("m_data_rx", m_data_rx, exp_m_rx);
    chk("s_data_rx", s_data_rx, exp_s_rx);
    chk("mosi_quiet_rx", mosi_hi, 0);
    chk("ss_idle", m_ss, 1);
  endtask

  initial begin
    int cnt, md0, sd0;
    logic prev;
    logic [7:0] ab;
    reset = 1'b1; m_start = 1'b0; m_write_enable = 1'b0; m_clock_div = 3'd3;
    m_data_tx = 8'h00; s_data_tx = 8'h00; s_write_enable = 1'b1;
    ext = 1'b0; x_sclk = 1'b0; x_ss = 1'b1; x_mosi = 1'b0;
    exp_m_rx = 8'h00; exp_s_rx = 8'h00;
    vecs[0] = '{1'b0, 1'b1, 3'd3, 8'hAA, 8'h55, 8'h00, 8'hAA};
    vecs[1] = '{1'b1, 1'b0, 3'd3, 8'h12, 8'h6D, 8'h6D, 8'hAA};
    vecs[2] = '{1'b0, 1'b0, 3'd4, 8'hF0, 8'h0F, 8'h6D, 8'hAA};
    vecs[3] = '{1'b1, 1'b1, 3'd3, 8'h77, 8'h99, 8'h00, 8'h00};
    vecs[4] = '{1'b0, 1'b1, 3'd5, 8'hC5, 8'h00, 8'h00, 8'hC5};
    repeat (2) @(negedge clock);
    chk("rst_m_ss", m_ss, 1);
    chk("rst_m_sclk", m_sclk, 0);
    chk("rst_m_mosi", m_mosi, 0);
    chk("rst_m_data_rx", m_data_rx, 0);
    chk("rst_s_data_rx", s_data_rx, 0);
    chk("rst_s_miso", s_miso, 0);
    chk("rst_dones", {m_done, s_done}, 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].mwe, vecs[i].swe, vecs[i].div, vecs[i].mtx, vecs[i].stx, 0);
      chk("tbl_m_rx", m_data_rx, vecs[i].em);
      chk("tbl_s_rx", s_data_rx, vecs[i].es);
    end
    // start held high must not launch another frame
    run_frame(1'b0, 1'b1, 3'd3, 8'h11, 8'h00, 1);
    cnt = 0;
    repeat (300) begin
      @(negedge clock);
      if (!m_ss) cnt++;
    end
    chk("no_retrigger", cnt, 0);
    run_frame(1'b0, 1'b1, 3'd3, 8'h3C, 8'h00, 0);
    chk("retrigger_rx", s_data_rx, 8'h3C);
    // slave abort after 4 bits
    ext = 1'b1;
    sd0 = sd_total;
    ab = 8'hF5;
    @(negedge clock);
    x_ss = 1'b0;
    repeat (8) @(negedge clock);
    for (int b = 0; b < 4; b++) begin
      x_mosi = ab[7 - b];
      repeat (4) @(negedge clock);
      x_sclk = 1'b1;
      repeat (4) @(negedge clock);
      x_sclk = 1'b0;
    end
    repeat (4) @(negedge clock);
    x_ss = 1'b1;
    repeat (10) @(negedge clock);
    chk("abort_no_s_done", sd_total - sd0, 0);
    chk("abort_s_rx_kept", s_data_rx, 8'h3C);
    ext = 1'b0;
    run_frame(1'b0, 1'b1, 3'd3, 8'h81, 8'h00, 0);
    chk("after_abort_rx", s_data_rx, 8'h81);
    // reset in the middle of a frame
    @(negedge clock);
    m_write_enable = 1'b0; s_write_enable = 1'b1; m_clock_div = 3'd3; m_data_tx = 8'hE7;
    m_start = 1'b0;
    @(negedge clock);
    m_start = 1'b1;
    cnt = 0; prev = 1'b0;
    for (int i = 0; i < 500 && cnt < 3; i++) begin
      @(negedge clock);
      if (m_sclk && !prev) cnt++;
      prev = m_sclk;
    end
    chk("midframe_reached", cnt, 3);
    md0 = md_total; sd0 = sd_total;
    m_start = 1'b0; reset = 1'b1;
    @(negedge clock);
    chk("midrst_m_ss", m_ss, 1);
    chk("midrst_m_sclk", m_sclk, 0);
    chk("midrst_m_done", m_done, 0);
    reset = 1'b0;
    exp_m_rx = 8'h00; exp_s_rx = 8'h00;
    repeat (40) @(negedge clock);
    chk("midrst_no_done", (md_total - md0) + (sd_total - sd0), 0);
    chk("midrst_m_ss_idle", m_ss, 1);
    chk("midrst_s_rx", s_data_rx, 8'h00);
    run_frame(1'b0, 1'b1, 3'd3, 8'h5A, 8'h00, 0);
    chk("after_rst_rx", s_data_rx, 8'h5A);
    for (int i = 0; i < 20; i++)
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(3, 5)),
                8'($urandom), 8'($urandom), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_master_slave_pair.md
Name: spi_master_slave_pair

Overview:
- 8-bit SPI block with an independent master engine and slave engine, both clocked by the single system clock.
- The master generates sclk/ss/MOSI from the system clock using a programmable divider.
- The slave oversamples an external sclk/ss/MOSI through synchronizers and drives MISO.
- Both engines use SPI mode 0 (CPOL=0, CPHA=0), MSB first, with one 8-bit frame per ss assertion. The bench or system wires master pins to slave pins (or to external devices).

Parameters:
- WIDTH, 8, frame length in bits. Fixed: all widths below assume 8.
- SYNC_STAGES, 2, synchronizer depth on the slave's s_sclk, s_ss and s_mosi inputs.

Ports:
- clock  in  1  system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- m_start  in  1  master: a 0->1 transition (sampled on clock) requests a frame
- m_write_enable  in  1  master: 0 = transmit frame, 1 = receive frame
- m_clock_div  in  3  master: sclk half-period H = 2^(m_clock_div-1) clocks; code 0 gives H=1
- m_data_tx  in  8  master: transmit data
- m_miso  in  1  master: serial input
- m_sclk  out  1  master: serial clock
- m_ss  out  1  master: slave select, active low
- m_mosi  out  1  master: serial output
- m_data_rx  out  8  master: last received frame
- m_done  out  1  master: one-clock pulse at end of frame
- s_sclk  in  1  slave: serial clock
- s_ss  in  1  slave: select, active low
- s_mosi  in  1  slave: serial input
- s_write_enable  in  1  slave: 1 = receive frame, 0 = transmit frame
- s_data_tx  in  8  slave: transmit data
- s_miso  out  1  slave: serial output
- s_data_rx  out  8  slave: last received frame
- s_done  out  1  slave: one-clock pulse after 8th bit

Behaviour:
- Reset (synchronous, active-high) values: m_sclk=0, m_ss=1, m_mosi=0, m_data_rx=0, m_done=0, s_miso=0, s_data_rx=0, s_done=0. All counters and state return to idle. Reset during a frame aborts it, with no done pulse.

Master FSM: IDLE -> SETUP -> HIGH -> LOW -> ... -> FINISH -> IDLE.
- IDLE:
  - Outputs m_ss=1, m_sclk=0, m_mosi=0.
  - A start edge (m_start=1 and registered previous m_start=0) latches m_data_tx, m_write_enable and m_clock_div. It then drives m_ss=0 and presents bit7 on m_mosi.
  - A start held high does not retrigger; m_start must return low for at least one clock first.
- SETUP: wait H clocks, then m_sclk=1.
- HIGH: on entry, sample m_miso into the shift register. After H clocks, m_sclk=0.
- LOW: shift so the next bit appears on m_mosi, then wait H clocks before the next rise.
- FINISH: after the 8th rise, wait H clocks and set m_sclk=0. Next clock: m_ss=1, m_done=1 for one clock, and m_data_rx updated if receive mode.
- Transmit mode (write_enable=0): m_mosi carries data, m_data_rx is unchanged.
- Receive mode (write_enable=1): m_mosi is held 0 and m_data_rx captures m_miso bits, MSB first.
- Frame length: 2 + 16*H clocks from start edge to m_done.

Slave engine:
- Edge detection operates on synchronized copies of s_sclk, s_ss and s_mosi.
- Synchronized s_ss falling:
  - clear the bit counter;
  - in transmit mode, load s_data_tx and drive bit7 on s_miso;
  - in receive mode, hold s_miso at 0.
  - s_write_enable and s_data_tx are latched at this edge.
- Synchronized s_sclk rising, with s_ss low: shift s_mosi in and increment the counter. On the 8th rise, pulse s_done for one clock; in receive mode also update s_data_rx. Further rises before s_ss goes high are ignored.
- Synchronized s_sclk falling, with s_ss low: present the next tx bit on s_miso.
- s_ss high: s_miso=0. If s_ss rises before 8 bits, the frame is aborted: no s_done, s_data_rx unchanged.
- Required: sclk half-period >= 4 system clocks, i.e. m_clock_div >= 3 when master and slave are looped back in this block.

Test Plan:
1. Reset asserted for 2 clocks -> m_ss=1, m_sclk=0, m_data_rx=0, s_data_rx=0, no done pulses.
2. Loopback with m_clock_div=3, m_write_enable=0, s_write_enable=1, m_data_tx=8'hAA, start edge -> exactly 8 sclk rises at 8-clock period, s_data_rx=8'hAA, one s_done and one m_done pulse, m_data_rx unchanged.
3. Loopback with m_write_enable=1, s_write_enable=0, s_data_tx=8'h6D, new start edge -> m_data_rx=8'h6D, m_mosi stays 0, s_data_rx unchanged.
4. m_start held high after a frame -> no second frame. m_start low then high -> second frame with new data 8'h3C received correctly.
5. Abort: drive s_ss low, give 4 sclk pulses, raise s_ss -> no s_done, s_data_rx retains its prior value. Next full frame of 8'h81 is received correctly.
6. Assert reset mid-frame (after 3 bits) -> next clock m_ss=1, m_sclk=0, no m_done. A subsequent frame of 8'h5A completes correctly.
